// File: rtl/addr_q_pkg.sv
// addr_q_pkg: shared constants and types for the address request queue
package addr_q_pkg;
   localparam int AW_DEF = 32;
   localparam int OFFSET_BITS_DEF = 6;
   localparam int CNT_W_DEF = 20;
   typedef logic [AW_DEF-OFFSET_BITS_DEF-1:0] blk_addr_t;
   typedef logic [CNT_W_DEF-1:0] seq_t;
   typedef struct packed {
      logic [AW_DEF-1:0] addr;
      seq_t seq;
   } q_entry_t;
endpackage

// File: rtl/addr_req_queue_if.sv
// addr_req_queue_if: loader-side and cache-side valid/ready handshakes
interface addr_req_queue_if #(
   parameter int AW = 32,
   parameter int CNT_W = 20
);
   logic in_valid;
   logic in_ready;
   logic [AW-1:0] in_addr;
   logic out_valid;
   logic out_ready;
   logic [AW-1:0] out_addr;
   logic [CNT_W-1:0] out_seq;
   modport master (output in_valid, in_addr, out_ready, input in_ready, out_valid, out_addr, out_seq);
   modport slave (input in_valid, in_addr, out_ready, output in_ready, out_valid, out_addr, out_seq);
endinterface

// File: rtl/addr_q_storage.sv
// addr_q_storage: DEPTH-entry register array, one sync write port, async read at head
module addr_q_storage
   import addr_q_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter type T = q_entry_t
) (
   input logic clock,
   input logic we,
   input logic [$clog2(DEPTH)-1:0] wptr,
   input logic [$clog2(DEPTH)-1:0] rptr,
   input T wdata,
   output T rdata
);
   T mem_q [DEPTH];
   T mem_d [DEPTH];
   always_comb begin
      mem_d = mem_q;
      mem_d[wptr] = we ? wdata : mem_q[wptr];
   end
   always_ff @(posedge clock) mem_q <= mem_d;
   assign rdata = mem_q[rptr];
endmodule

// File: rtl/addr_req_queue.sv
// addr_req_queue: FWFT request FIFO with sequence tags and accepted/dropped counters.
// Define ADDR_Q_COALESCE_EN to drop pushes hitting the same block as the previous accepted push.
module addr_req_queue
   import addr_q_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW = AW_DEF,
   parameter int OFFSET_BITS = OFFSET_BITS_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic clock,
   input logic reset,
   addr_req_queue_if.slave bus,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0] accepted_cnt,
   output logic [CNT_W-1:0] dropped_cnt
);
   localparam int PW = $clog2(DEPTH);
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [CNT_W-1:0] seq;
   } entry_t;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0] level_q, level_d;
   logic [CNT_W-1:0] seq_ctr_q, seq_ctr_d, acc_q, acc_d;
   logic push, pop, drop, enq;
   entry_t wr_entry, head;
   assign bus.in_ready = level_q < (PW+1)'(DEPTH);
   assign bus.out_valid = level_q != '0;
   assign push = bus.in_valid && bus.in_ready;
   assign pop = bus.out_valid && bus.out_ready;
   assign enq = push && !drop;
   assign wr_entry = '{addr: bus.in_addr, seq: seq_ctr_q};
   assign bus.out_addr = head.addr;
   assign bus.out_seq = head.seq;
   assign level = level_q;
   assign accepted_cnt = acc_q;
   always_comb begin
      wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d = level_q + (PW+1)'(enq) - (PW+1)'(pop);
      seq_ctr_d = enq ? seq_ctr_q + 1'b1 : seq_ctr_q;
      acc_d = enq ? acc_q + 1'b1 : acc_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q <= '0;
         seq_ctr_q <= '0;
         acc_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q <= level_d;
         seq_ctr_q <= seq_ctr_d;
         acc_q <= acc_d;
      end
   end
`ifdef ADDR_Q_COALESCE_EN
   logic [AW-OFFSET_BITS-1:0] last_blk_q, last_blk_d;
   logic last_vld_q, last_vld_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   // a dropped push still completes its handshake; it just leaves no entry behind
   assign drop = last_vld_q && (bus.in_addr[AW-1:OFFSET_BITS] == last_blk_q);
   assign dropped_cnt = drop_cnt_q;
   always_comb begin
      last_blk_d = enq ? bus.in_addr[AW-1:OFFSET_BITS] : last_blk_q;
      last_vld_d = last_vld_q || enq;
      drop_cnt_d = (push && drop) ? drop_cnt_q + 1'b1 : drop_cnt_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         last_blk_q <= '0;
         last_vld_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         last_blk_q <= last_blk_d;
         last_vld_q <= last_vld_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
`else
   assign drop = 1'b0;
   assign dropped_cnt = '0;
`endif
   addr_q_storage #(.DEPTH(DEPTH), .T(entry_t)) u_storage (
      .clock(clock),
      .we(enq),
      .wptr(wr_ptr_q),
      .rptr(rd_ptr_q),
      .wdata(wr_entry),
      .rdata(head)
   );
endmodule

// File: tb/tb_addr_req_queue.sv
// tb_addr_req_queue: table vectors plus scoreboard-checked corner sequences
module tb_addr_req_queue;
   localparam int DEPTH = 8;
   localparam int AW = 32;
   localparam int CNT_W = 20;
`ifdef ADDR_Q_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif
   typedef struct {
      logic [31:0] a;
      logic [19:0] s;
   } exp_t;
   typedef struct {
      logic v;
      logic [31:0] a;
      logic r;
      int lvl;
      int acc;
   } vec_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [3:0] level;
   logic [19:0] acc, drp;
   int n_chk = 0;
   int n_fail = 0;
   exp_t sb[$];
   logic [19:0] m_seq, m_acc, m_drp;
   logic [25:0] m_last_blk;
   bit m_last_vld;
   vec_t tbl[10];
   addr_req_queue_if #(.AW(AW), .CNT_W(CNT_W)) bus ();
   addr_req_queue #(.DEPTH(DEPTH), .AW(AW), .OFFSET_BITS(6), .CNT_W(CNT_W)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave),
      .level(level),
      .accepted_cnt(acc),
      .dropped_cnt(drp)
   );
   always #5 clock = ~clock;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_addr = '0;
      bus.out_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      sb.delete();
      m_seq = '0;
      m_acc = '0;
      m_drp = '0;
      m_last_blk = '0;
      m_last_vld = 1'b0;
   endtask
   // drive one cycle, check state against the model, then advance the model
   task automatic step(input logic v, input logic [31:0] a, input logic r);
      bit push, pop, drop;
      bus.in_valid = v;
      bus.in_addr = a;
      bus.out_ready = r;
      #1;
      chk("in_ready", bus.in_ready, sb.size() < DEPTH);
      chk("out_valid", bus.out_valid, sb.size() != 0);
      chk("level", level, sb.size());
      chk("accepted_cnt", acc, m_acc);
      chk("dropped_cnt", drp, m_drp);
      if (sb.size() != 0) begin
         chk("out_addr", bus.out_addr, sb[0].a);
         chk("out_seq", bus.out_seq, sb[0].s);
      end
      push = v && (sb.size() < DEPTH);
      pop = r && (sb.size() != 0);
      drop = COAL && m_last_vld && (a[31:6] == m_last_blk);
      @(posedge clock);
      #1;
      if (pop) void'(sb.pop_front());
      if (push) begin
         if (drop) m_drp++;
         else begin
            sb.push_back('{a, m_seq});
            m_seq++;
            m_acc++;
            m_last_blk = a[31:6];
            m_last_vld = COAL;
         end
      end
   endtask
   task automatic drain();
      for (int i = 0; i < DEPTH + 2 && sb.size() != 0; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("drain_out_valid", bus.out_valid, 1'b0);
   endtask
   initial begin
      tbl = '{
         '{1'b1, 32'h1000, 1'b0, 1, 1},
         '{1'b1, 32'h2000, 1'b0, 2, 2},
         '{1'b1, 32'h3000, 1'b0, 3, 3},
         '{1'b0, 32'h0, 1'b1, 2, 3},
         '{1'b0, 32'h0, 1'b1, 1, 3},
         '{1'b0, 32'h0, 1'b1, 0, 3},
         '{1'b0, 32'h0, 1'b0, 0, 3},
         '{1'b1, 32'h4000, 1'b0, 1, 4},
         '{1'b1, 32'h5000, 1'b1, 1, 5},
         '{1'b0, 32'h0, 1'b1, 0, 5}
      };
      do_reset();
      chk("rst_level", level, 0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].a, tbl[i].r);
         chk("tbl_level", level, tbl[i].lvl);
         chk("tbl_accepted", acc, tbl[i].acc);
      end
      // fill to full, then an ignored ninth push
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h2000 + i * 32'h100, 1'b0);
      chk("full_in_ready", bus.in_ready, 1'b0);
      chk("full_level", level, 8);
      step(1'b1, 32'hDEAD0000, 1'b0);
      chk("ovf_level", level, 8);
      chk("ovf_accepted", acc, 8);
      // full with continuous push and pop
      step(1'b1, 32'h4000, 1'b1);
      chk("first_pop_level", level, 7);
      chk("first_pop_in_ready", bus.in_ready, 1'b1);
      for (int i = 1; i < 12; i++) begin
         step(1'b1, 32'h4000 + i * 32'h100, 1'b1);
         chk("stream_level", level, 7);
      end
      drain();
      // reset with five entries queued
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 32'h8000 + i * 32'h100, 1'b0);
      chk("pre_rst_level", level, 5);
      do_reset();
      chk("mid_rst_level", level, 0);
      chk("mid_rst_out_valid", bus.out_valid, 1'b0);
      chk("mid_rst_accepted", acc, 0);
      step(1'b1, 32'hABC0, 1'b0);
      chk("abc0_seq", bus.out_seq, 20'h0);
      chk("abc0_addr", bus.out_addr, 32'hABC0);
      drain();
      // block coalescing
      do_reset();
      step(1'b1, 32'h1000, 1'b0);
      step(1'b1, 32'h1004, 1'b0);
      step(1'b1, 32'h103C, 1'b0);
      step(1'b1, 32'h1040, 1'b0);
      chk("coal_level", level, COAL ? 2 : 4);
      chk("coal_dropped", drp, COAL ? 2 : 0);
      chk("coal_accepted", acc, COAL ? 2 : 4);
      drain();
      // sequence tag wrap
      do_reset();
      force dut.seq_ctr_q = 20'hFFFFF;
      step(1'b0, '0, 1'b0);
      release dut.seq_ctr_q;
      m_seq = 20'hFFFFF;
      step(1'b1, 32'h9000, 1'b0);
      step(1'b1, 32'h9100, 1'b0);
      chk("wrap_head_seq", bus.out_seq, 20'hFFFFF);
      step(1'b0, '0, 1'b1);
      chk("wrap_next_seq", bus.out_seq, 20'h00000);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/addr_req_queue.md
# addr_req_queue

Buffered address-request stage sitting directly upstream of the compressed-cache top (`mainMod`). It accepts word addresses from the trace loader over a valid/ready handshake, holds them in a DEPTH-entry FIFO, and presents them one at a time to the cache with a monotonically increasing sequence tag. It also maintains accepted/dropped counters, which give the cache-statistics logic a reliable request count.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- AW, 32, address width
- OFFSET_BITS, 6, block-offset bits (64 B block); block address = addr[AW-1:OFFSET_BITS]
- CNT_W, 20, width of sequence tag and counters
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  loader presents in_addr
- in_ready  out  1  queue can take a request
- in_addr  in  AW  request address
- out_valid  out  1  head entry valid
- out_ready  in  1  cache consumes head
- out_addr  out  AW  head address
- out_seq  out  CNT_W  sequence tag of head
- level  out  $clog2(DEPTH)+1  current occupancy
- accepted_cnt  out  CNT_W  enqueued requests
- dropped_cnt  out  CNT_W  coalesced (dropped) requests

## Operation
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (level < DEPTH); registered-state only, no combinational path from out_ready.
- Push enqueues {in_addr, seq_ctr}; seq_ctr and accepted_cnt then increment, wrapping mod 2^CNT_W.
- Head is first-word-fall-through: out_addr/out_seq reflect the oldest entry whenever out_valid=1.
- Empty: out_valid=0, and out_addr/out_seq are don't-care (bench must not check them).
- Full: in_ready=0, and in_valid is ignored with no state change.
- Simultaneous push and pop, not full: level unchanged, and both operations take effect.
- Simultaneous push and pop when full: in_ready is 0, so only the pop occurs.
- Pointers are $clog2(DEPTH) bits and wrap naturally; level is updated as +1/−1/0.
- Reset values: in_ready=1, out_valid=0, level=0, accepted_cnt=0, dropped_cnt=0, seq_ctr=0, pointers=0, last_vld=0.
- Reset during operation discards all entries in the same cycle; the next cycle behaves as empty.

## Timing
- Push to out_valid on an empty queue: 1 cycle (entry visible the cycle after the push edge).
- Pop to next head visible: same cycle as the pop edge, with no bubble while entries remain.
- Sustained throughput: 1 request/cycle when out_ready is held high and level < DEPTH.
- Counters update on the clock edge of the qualifying push.

## Configuration
- ADDR_Q_COALESCE_EN defined:
  - A register last_blk/last_vld holds the block address of the most recent accepted push.
  - A push whose block address equals last_blk while last_vld=1 is dropped: the handshake completes (in_ready semantics unchanged), nothing is enqueued, dropped_cnt increments, and seq_ctr does not advance.
  - Non-matching pushes update last_blk and set last_vld.
  - Reset clears last_vld.
- ADDR_Q_COALESCE_EN not defined:
  - Every push is enqueued.
  - dropped_cnt is tied to 0.
  - The last_blk logic is not generated.

## Structure
- Package addr_q_pkg holds:
  - AW_DEF, OFFSET_BITS_DEF and CNT_W_DEF constants
  - typedef blk_addr_t = logic [AW-OFFSET_BITS-1:0]
  - typedef seq_t = logic [CNT_W-1:0]
  - typedef q_entry_t = struct {addr, seq}
- Sub-module addr_q_storage: a DEPTH×q_entry_t register array with one synchronous write port and an asynchronous read at the head pointer.
- Pointers, level and counters stay in the top module.

## Test plan
- Reset, then push 0x1000, 0x2000, 0x3000 with out_ready=0 → level=3, out_addr=0x1000, out_seq=0; raise out_ready for 3 cycles → outputs 0x1000/0, 0x2000/1, 0x3000/2, then out_valid=0.
- Push 8 distinct addresses with out_ready=0 → in_ready=0 after the 8th push; a 9th in_valid is ignored; level=8; accepted_cnt=8.
- Full queue, then out_ready=1 and in_valid=1 continuously → 1 pop/cycle; in_ready returns the cycle after the first pop; order is preserved.
- Reset asserted with level=5 → next cycle level=0, out_valid=0, accepted_cnt=0; a following push of 0xABC0 gets out_seq=0.
- With ADDR_Q_COALESCE_EN: push 0x1000, 0x1004, 0x103C, 0x1040 → only 0x1000 (seq 0) and 0x1040 (seq 1) are enqueued; dropped_cnt=2. Without the macro, the same stimulus enqueues all 4 with seq 0–3.
- Force seq_ctr to 2^20−1 and push twice → out_seq values 0xFFFFF then 0x00000.
